// File: rtl/clk_div_ratio_ctrl_if.sv
// Ratio-change request channel between a requester and clk_div_ratio_ctrl.
// The requester holds req_valid and req_ratio steady until it sees req_ready.
interface clk_div_ratio_ctrl_if;
   logic       req_valid;
   logic [7:0] req_ratio;
   logic       req_ready;

   modport master (output req_valid, output req_ratio, input req_ready);
   modport slave  (input req_valid, input req_ratio, output req_ready);
endinterface

// File: rtl/clk_div_ratio_ctrl.sv
// Ratio/enable/reset control for the integer clock divider; new ratios are applied only while
// the divider is held in reset. Define CLK_DIV_CTRL_WAIT_LOW_EN to wait for the divided clock low phase.
module clk_div_ratio_ctrl #(
   parameter int unsigned DEFAULT_RATIO = 8,
   parameter int unsigned MAX_RATIO     = 255,
   parameter int unsigned QUIESCE_CYC   = 2,
   parameter int unsigned WAIT_TMO      = 512
) (
   input  logic                       i_ref_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_div_clk,
   clk_div_ratio_ctrl_if.slave        req_if,
   output logic [7:0]                 o_div_ratio,
   output logic                       o_clk_en,
   output logic                       o_div_rst_n,
   output logic                       o_busy,
   output logic                       o_err,
   output logic                       o_done
);

   localparam logic [7:0] DefRatio    = 8'(DEFAULT_RATIO);
   localparam logic [7:0] QuiesceLast = 8'(QUIESCE_CYC - 1);

   typedef enum logic [2:0] {StInit, StIdle, StWaitLow, StQuiesce, StApply} state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] pend_q, pend_d;
   logic [7:0] ratio_q, ratio_d;
   logic       run_en_q, run_en_d;
   logic       rst_n_q, rst_n_d;
   logic       clk_en_q;
   logic       ready_q, busy_q;
   logic       err_q, err_d;
   logic       done_q, done_d;
   logic       req_fire, ratio_ok;

`ifdef CLK_DIV_CTRL_WAIT_LOW_EN
   localparam logic [9:0] TmoLast = 10'(WAIT_TMO - 1);
   logic [9:0] tmo_q, tmo_d;
`else
   logic unused_div_clk;
   assign unused_div_clk = i_div_clk;
`endif

   assign req_fire = req_if.req_valid & ready_q;
   assign ratio_ok = (req_if.req_ratio >= 8'd2) && (32'(req_if.req_ratio) <= MAX_RATIO);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      ratio_d  = ratio_q;
      run_en_d = run_en_q;
      rst_n_d  = rst_n_q;
      err_d    = 1'b0;
      done_d   = 1'b0;
`ifdef CLK_DIV_CTRL_WAIT_LOW_EN
      tmo_d    = tmo_q;
`endif
      unique case (state_q)
         StInit: begin
            if (cnt_q == QuiesceLast) begin
               cnt_d    = '0;
               rst_n_d  = 1'b1;
               run_en_d = 1'b1;
               state_d  = StIdle;
            end else if (cnt_q != 8'hff) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StIdle: begin
            if (req_fire) begin
               if (!ratio_ok) begin
                  err_d = 1'b1;
               end else if (req_if.req_ratio == ratio_q) begin
                  done_d = 1'b1;
               end else begin
                  pend_d = req_if.req_ratio;
`ifdef CLK_DIV_CTRL_WAIT_LOW_EN
                  tmo_d   = '0;
                  state_d = StWaitLow;
`else
                  cnt_d    = '0;
                  run_en_d = 1'b0;
                  rst_n_d  = 1'b0;
                  state_d  = StQuiesce;
`endif
               end
            end
         end
         StWaitLow: begin
`ifdef CLK_DIV_CTRL_WAIT_LOW_EN
            // A disabled divider has no phase to protect, so leave at once.
            if (!i_div_clk || !clk_en_q || (tmo_q >= TmoLast)) begin
               cnt_d    = '0;
               run_en_d = 1'b0;
               rst_n_d  = 1'b0;
               state_d  = StQuiesce;
            end else if (tmo_q != 10'h3ff) begin
               tmo_d = tmo_q + 10'd1;
            end
`else
            state_d = StIdle;
`endif
         end
         StQuiesce: begin
            if (cnt_q == QuiesceLast) begin
               cnt_d   = '0;
               ratio_d = pend_q;
               state_d = StApply;
            end else if (cnt_q != 8'hff) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StApply: begin
            rst_n_d  = 1'b1;
            run_en_d = 1'b1;
            done_d   = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= StInit;
         cnt_q    <= '0;
         pend_q   <= '0;
         ratio_q  <= DefRatio;
         run_en_q <= 1'b0;
         rst_n_q  <= 1'b0;
         clk_en_q <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b1;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
`ifdef CLK_DIV_CTRL_WAIT_LOW_EN
         tmo_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         ratio_q  <= ratio_d;
         run_en_q <= run_en_d;
         rst_n_q  <= rst_n_d;
         clk_en_q <= run_en_d & i_en;
         ready_q  <= (state_d == StIdle);
         busy_q   <= (state_d != StIdle);
         err_q    <= err_d;
         done_q   <= done_d;
`ifdef CLK_DIV_CTRL_WAIT_LOW_EN
         tmo_q    <= tmo_d;
`endif
      end
   end

   assign req_if.req_ready = ready_q;
   assign o_div_ratio      = ratio_q;
   assign o_clk_en         = clk_en_q;
   assign o_div_rst_n      = rst_n_q;
   assign o_busy           = busy_q;
   assign o_err            = err_q;
   assign o_done           = done_q;

endmodule
